// File: rtl/chip_gate_tester_pkg.sv
// rtl/chip_gate_tester_pkg.sv - states, gate modes and expected-output function for chip_gate_tester
package chip_tester_pkg;

  typedef enum logic [2:0] {
    HALTED,
    SET,
    DRIVE,
    SETTLE,
    CHECK,
    DONE_S
  } tester_state_e;

  typedef enum logic [2:0] {
    MODE_NAND = 3'd0,
    MODE_NOR  = 3'd1,
    MODE_AND  = 3'd2,
    MODE_OR   = 3'd3,
    MODE_XOR  = 3'd4,
    MODE_XNOR = 3'd5
  } gate_mode_e;

  // Expected gate output for the low n bits of vec under the given function.
  function automatic logic gate_expect(gate_mode_e mode, logic [3:0] vec, int n);
    logic v_and;
    logic v_or;
    logic v_xor;
    v_and = 1'b1;
    v_or  = 1'b0;
    v_xor = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        v_and = v_and & vec[i];
        v_or  = v_or | vec[i];
        v_xor = v_xor ^ vec[i];
      end
    end
    case (mode)
      MODE_NAND: gate_expect = ~v_and;
      MODE_NOR:  gate_expect = ~v_or;
      MODE_AND:  gate_expect = v_and;
      MODE_OR:   gate_expect = v_or;
      MODE_XOR:  gate_expect = v_xor;
      MODE_XNOR: gate_expect = ~v_xor;
      default:   gate_expect = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/chip_gate_tester_if.sv
// rtl/chip_gate_tester_if.sv - control, pin and result bundle of chip_gate_tester; FAIL_LOG_EN adds first-failure fields
interface chip_gate_tester_if #(
  parameter int N_GATES  = 4,
  parameter int N_INPUTS = 2
);
  logic                          Run;
  logic [2:0]                    Mode;
  logic                          DISP_RSLT;
  logic [N_GATES*N_INPUTS-1:0]   DrvOut;
  logic [N_GATES-1:0]            SenseIn;
  logic                          Done;
  logic                          RSLT;
  logic [N_GATES-1:0]            FailMask;
`ifdef FAIL_LOG_EN
  logic                          FailValid;
  logic [N_INPUTS-1:0]           FailVec;
  logic [$clog2(N_GATES)-1:0]    FailGate;

  modport master (output Run, Mode, DISP_RSLT, SenseIn,
                  input  DrvOut, Done, RSLT, FailMask, FailValid, FailVec, FailGate);
  modport slave  (input  Run, Mode, DISP_RSLT, SenseIn,
                  output DrvOut, Done, RSLT, FailMask, FailValid, FailVec, FailGate);
`else
  modport master (output Run, Mode, DISP_RSLT, SenseIn,
                  input  DrvOut, Done, RSLT, FailMask);
  modport slave  (input  Run, Mode, DISP_RSLT, SenseIn,
                  output DrvOut, Done, RSLT, FailMask);
`endif
endinterface

// File: rtl/chip_gate_tester_sense_sync.sv
// rtl/chip_gate_tester_sense_sync.sv - two-flop synchroniser for the asynchronous gate outputs
module sense_sync #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two-stage capture so CHECK only ever sees a resolved level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/chip_gate_tester.sv
// rtl/chip_gate_tester.sv - exhaustive N-input gate chip tester; FAIL_LOG_EN enables first-failure capture
module chip_gate_tester
  import chip_tester_pkg::*;
#(
  parameter int N_GATES       = 4,
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  chip_gate_tester_if.slave bus
);
  localparam int VW = N_INPUTS + 1;
  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam logic [VW-1:0] LAST_VEC = VW'((1 << N_INPUTS) - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 2);

  tester_state_e               r_state, w_state_nxt;
  logic [VW-1:0]               r_vec, w_vec_nxt, w_vec_inc;
  logic [CW-1:0]               r_cnt, w_cnt_nxt;
  logic [2:0]                  r_mode, w_mode_nxt;
  logic [N_GATES*N_INPUTS-1:0] r_drv, w_drv_nxt;
  logic [N_GATES-1:0]          r_fail, w_fail_nxt;
  logic                        r_rslt, w_rslt_nxt;
  logic                        r_done;
  logic [N_GATES-1:0]          w_sense, w_mis;
  logic [3:0]                  w_vec4;
  logic                        w_exp;
`ifdef FAIL_LOG_EN
  localparam int GW = $clog2(N_GATES);
  logic                        r_fvalid, w_fvalid_nxt;
  logic [N_INPUTS-1:0]         r_fvec, w_fvec_nxt;
  logic [GW-1:0]               r_fgate, w_fgate_nxt, w_first_gate;
`endif

  sense_sync #(.W(N_GATES)) u_sense_sync (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_d     (bus.SenseIn),
    .o_q     (w_sense)
  );

  // Per-gate mismatch of the synchronised pins against the selected function.
  always_comb begin
    w_vec4                 = '0;
    w_vec4[N_INPUTS-1:0]   = r_vec[N_INPUTS-1:0];
    w_vec_inc              = r_vec + 1'b1;
    w_exp                  = gate_expect(gate_mode_e'(r_mode), w_vec4, N_INPUTS);
    w_mis                  = w_sense ^ {N_GATES{w_exp}};
`ifdef FAIL_LOG_EN
    w_first_gate = '0;
    for (int g = N_GATES - 1; g >= 0; g--) begin
      if (w_mis[g]) w_first_gate = GW'(g);
    end
`endif
  end

  // Next state and next datapath values.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_drv_nxt   = r_drv;
    w_fail_nxt  = r_fail;
    w_rslt_nxt  = r_rslt;
`ifdef FAIL_LOG_EN
    w_fvalid_nxt = r_fvalid;
    w_fvec_nxt   = r_fvec;
    w_fgate_nxt  = r_fgate;
`endif
    case (r_state)
      HALTED: if (bus.Run) w_state_nxt = SET;
      SET: begin
        w_mode_nxt = bus.Mode;
        w_vec_nxt  = '0;
        w_drv_nxt  = '0;
`ifdef FAIL_LOG_EN
        w_fvalid_nxt = 1'b0;
        w_fvec_nxt   = '0;
        w_fgate_nxt  = '0;
`endif
        if (bus.Mode >= 3'd6) begin
          w_fail_nxt  = '1;
          w_rslt_nxt  = 1'b0;
          w_state_nxt = DONE_S;
        end else begin
          w_fail_nxt  = '0;
          w_rslt_nxt  = 1'b1;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = SETTLE;
      end
      SETTLE: begin
        if (r_cnt == CNT_LAST) w_state_nxt = CHECK;
        else                   w_cnt_nxt   = r_cnt + 1'b1;
      end
      CHECK: begin
        w_fail_nxt = r_fail | w_mis;
        if (|w_mis) w_rslt_nxt = 1'b0;
`ifdef FAIL_LOG_EN
        if (!r_fvalid && |w_mis) begin
          w_fvalid_nxt = 1'b1;
          w_fvec_nxt   = r_vec[N_INPUTS-1:0];
          w_fgate_nxt  = w_first_gate;
        end
`endif
        if (r_vec == LAST_VEC) begin
          w_drv_nxt   = '0;
          w_state_nxt = DONE_S;
        end else begin
          w_vec_nxt   = w_vec_inc;
          w_drv_nxt   = {N_GATES{w_vec_inc[N_INPUTS-1:0]}};
          w_state_nxt = DRIVE;
        end
      end
      DONE_S: begin
        w_drv_nxt = '0;
        if (bus.DISP_RSLT) w_state_nxt = HALTED;
      end
      default: w_state_nxt = HALTED;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= HALTED;
    else        r_state <= w_state_nxt;
  end

  // Datapath and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_vec  <= '0;
      r_cnt  <= '0;
      r_mode <= '0;
      r_drv  <= '0;
      r_fail <= '0;
      r_rslt <= 1'b0;
      r_done <= 1'b0;
`ifdef FAIL_LOG_EN
      r_fvalid <= 1'b0;
      r_fvec   <= '0;
      r_fgate  <= '0;
`endif
    end else begin
      r_vec  <= w_vec_nxt;
      r_cnt  <= w_cnt_nxt;
      r_mode <= w_mode_nxt;
      r_drv  <= w_drv_nxt;
      r_fail <= w_fail_nxt;
      r_rslt <= w_rslt_nxt;
      r_done <= (w_state_nxt == DONE_S);
`ifdef FAIL_LOG_EN
      r_fvalid <= w_fvalid_nxt;
      r_fvec   <= w_fvec_nxt;
      r_fgate  <= w_fgate_nxt;
`endif
    end
  end

  assign bus.DrvOut   = r_drv;
  assign bus.Done     = r_done;
  assign bus.RSLT     = r_rslt;
  assign bus.FailMask = r_fail;
`ifdef FAIL_LOG_EN
  assign bus.FailValid = r_fvalid;
  assign bus.FailVec   = r_fvec;
  assign bus.FailGate  = r_fgate;
`endif
endmodule

// File: tb/tb_chip_gate_tester.sv
// tb/tb_chip_gate_tester.sv - self-checking bench for chip_gate_tester (2-input and 3-input instances)
module tb_chip_gate_tester;
  localparam int NG = 4;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chip_gate_tester_if #(.N_GATES(NG), .N_INPUTS(2)) bus_a ();
  chip_gate_tester_if #(.N_GATES(NG), .N_INPUTS(3)) bus_b ();

  chip_gate_tester #(.N_GATES(NG), .N_INPUTS(2), .SETTLE_CYCLES(SC)) u_dut_a (
    .Clk(clk), .Reset(rst_n), .bus(bus_a));
  chip_gate_tester #(.N_GATES(NG), .N_INPUTS(3), .SETTLE_CYCLES(SC)) u_dut_b (
    .Clk(clk), .Reset(rst_n), .bus(bus_b));

  int          sel;
  logic        run_r, disp_r;
  logic [2:0]  mode_r;
  int          chip_kind;
  logic [NG-1:0] stuck0, stuck1;

  int n_assert = 0;
  int n_fail   = 0;

  logic        exp_rslt;
  logic [NG-1:0] exp_mask;
  logic        exp_fvalid;
  int          exp_fvec, exp_fgate;

  assign bus_a.Run       = run_r & (sel == 0);
  assign bus_b.Run       = run_r & (sel == 1);
  assign bus_a.DISP_RSLT = disp_r & (sel == 0);
  assign bus_b.DISP_RSLT = disp_r & (sel == 1);
  assign bus_a.Mode      = mode_r;
  assign bus_b.Mode      = mode_r;

  // Gate function from the count of ones among the n inputs.
  function automatic bit ref_fn(int kind, int v, int n);
    int ones;
    ones = $countones(v & ((1 << n) - 1));
    case (kind)
      0: return ones != n;
      1: return ones == 0;
      2: return ones == n;
      3: return ones != 0;
      4: return (ones % 2) == 1;
      5: return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Model chips: every gate computes chip_kind, then optional stuck faults.
  always_comb begin
    for (int g = 0; g < NG; g++) begin
      bus_a.SenseIn[g] = ref_fn(chip_kind, int'(bus_a.DrvOut[g*2 +: 2]), 2);
      if (stuck0[g]) bus_a.SenseIn[g] = 1'b0;
      if (stuck1[g]) bus_a.SenseIn[g] = 1'b1;
    end
  end

  always_comb begin
    for (int g = 0; g < NG; g++) begin
      bus_b.SenseIn[g] = ref_fn(chip_kind, int'(bus_b.DrvOut[g*3 +: 3]), 3);
      if (stuck0[g]) bus_b.SenseIn[g] = 1'b0;
      if (stuck1[g]) bus_b.SenseIn[g] = 1'b1;
    end
  end

  function automatic logic [11:0] drv();
    if (sel == 0) return {4'b0, bus_a.DrvOut};
    return bus_b.DrvOut;
  endfunction
  function automatic logic done();
    return (sel == 0) ? bus_a.Done : bus_b.Done;
  endfunction
  function automatic logic rslt();
    return (sel == 0) ? bus_a.RSLT : bus_b.RSLT;
  endfunction
  function automatic logic [NG-1:0] mask();
    return (sel == 0) ? bus_a.FailMask : bus_b.FailMask;
  endfunction

  function automatic logic [11:0] rep(int v, int n);
    logic [11:0] r;
    r = '0;
    for (int g = 0; g < NG; g++) r = r | (12'(v) << (g * n));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-test outcome computed directly from the vector list and fault map.
  task automatic predict(input int mode, input int n);
    bit s;
    exp_mask = '0; exp_rslt = 1'b1; exp_fvalid = 1'b0; exp_fvec = 0; exp_fgate = 0;
    if (mode >= 6) begin
      exp_mask = '1;
      exp_rslt = 1'b0;
      return;
    end
    for (int v = 0; v < (1 << n); v++) begin
      for (int g = 0; g < NG; g++) begin
        s = ref_fn(chip_kind, v, n);
        if (stuck0[g]) s = 1'b0;
        if (stuck1[g]) s = 1'b1;
        if (s != ref_fn(mode, v, n)) begin
          exp_mask[g] = 1'b1;
          exp_rslt    = 1'b0;
          if (!exp_fvalid) begin
            exp_fvalid = 1'b1; exp_fvec = v; exp_fgate = g;
          end
        end
      end
    end
  endtask

  task automatic run_test(input int s, input int mode, input bit restart, input int abort_k);
    int n, nv, klast;
    sel   = s;
    n     = s ? 3 : 2;
    nv    = 1 << n;
    klast = (mode >= 6) ? 1 : nv * (SC + 1) + 1;
    predict(mode, n);
    if (!restart) begin
      @(negedge clk);
      mode_r = 3'(mode);
      run_r  = 1'b1;
    end else begin
      mode_r = 3'(mode);
      @(posedge clk);
      @(negedge clk);
      chk("restart_halted_done", done(), 1'b0);
      disp_r = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    run_r = 1'b0;
    chk("set_done_low", done(), 1'b0);
    chk("set_drv_zero", drv(), 12'h0);
    for (int k = 1; k <= klast; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == abort_k) return;
      if (k == 1) begin
        chk("set_exit_rslt", rslt(), (mode >= 6) ? 1'b0 : 1'b1);
        chk("set_exit_mask", mask(), (mode >= 6) ? 4'hF : 4'h0);
        mode_r = 3'($urandom_range(0, 7));
      end
      chk("drv_seq", drv(), (k < klast) ? rep((k - 1) / (SC + 1), n) : 12'h0);
      chk("done_timing", done(), k == klast);
    end
    chk("final_rslt", rslt(), exp_rslt);
    chk("final_mask", mask(), exp_mask);
`ifdef FAIL_LOG_EN
    if (s == 0) begin
      chk("fail_valid", bus_a.FailValid, exp_fvalid);
      if (exp_fvalid) begin
        chk("fail_vec", bus_a.FailVec, exp_fvec);
        chk("fail_gate", bus_a.FailGate, exp_fgate);
      end
    end else begin
      chk("fail_valid", bus_b.FailValid, exp_fvalid);
      if (exp_fvalid) begin
        chk("fail_vec", bus_b.FailVec, exp_fvec);
        chk("fail_gate", bus_b.FailGate, exp_fgate);
      end
    end
`endif
    repeat (2) @(negedge clk);
    chk("done_held", done(), 1'b1);
  endtask

  task automatic release_dut();
    @(negedge clk);
    disp_r = 1'b1;
    @(posedge clk);
    @(negedge clk);
    disp_r = 1'b0;
    chk("release_done", done(), 1'b0);
    chk("release_rslt_held", rslt(), exp_rslt);
    chk("release_mask_held", mask(), exp_mask);
  endtask

  initial begin
    int m;
    run_r = 1'b0; disp_r = 1'b0; mode_r = '0; sel = 0;
    chip_kind = 0; stuck0 = '0; stuck1 = '0;

    repeat (3) @(negedge clk);
    chk("reset_drv", drv(), 12'h0);
    chk("reset_done", done(), 1'b0);
    chk("reset_rslt", rslt(), 1'b0);
    chk("reset_mask", mask(), 4'h0);
    rst_n = 1'b1;

    // NAND chip, NAND mode: all pass.
    run_test(0, 0, 1'b0, 0);
    chk("t1_rslt", rslt(), 1'b1);
    release_dut();

    // Gate 2 stuck at 0.
    stuck0 = 4'b0100;
    run_test(0, 0, 1'b0, 0);
    chk("t2_mask", mask(), 4'b0100);
    release_dut();
    stuck0 = '0;

    // Three-input XOR chip.
    chip_kind = 4;
    run_test(1, 4, 1'b0, 0);
    chk("t3_rslt", rslt(), 1'b1);
    release_dut();

    // Illegal mode goes straight to DONE_S.
    run_test(0, 6, 1'b0, 0);
    release_dut();

    // Reset in SETTLE of vector 2, then a clean rerun from vector 0.
    chip_kind = 0;
    run_test(0, 0, 1'b0, 12);
    rst_n = 1'b0;
    #1;
    chk("midreset_drv", drv(), 12'h0);
    chk("midreset_done", done(), 1'b0);
    chk("midreset_rslt", rslt(), 1'b0);
    chk("midreset_mask", mask(), 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_test(0, 0, 1'b0, 0);
    release_dut();

    // Failing result, then Run+DISP_RSLT held together restarts with cleared result.
    stuck1 = 4'b1000;
    run_test(0, 1, 1'b0, 0);
    @(negedge clk);
    run_r = 1'b1; disp_r = 1'b1;
    stuck1 = '0;
    run_test(0, 0, 1'b1, 0);
    release_dut();

    // Randomised modes, chips and faults on both instances.
    for (int i = 0; i < 12; i++) begin
      m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
      chip_kind = ($urandom_range(0, 1) == 1) ? m : int'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) begin
        stuck0 = 4'($urandom);
        stuck1 = 4'($urandom) & ~stuck0;
      end else begin
        stuck0 = '0;
        stuck1 = '0;
      end
      run_test(int'($urandom_range(0, 1)), m, 1'b0, 0);
      release_dut();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
